// File: rtl/pack_writeback.sv
// pack_writeback: packs an incoming byte stream into 32-bit BRAM words
// (little-endian lanes), then drains the whole frame one byte per cycle
// through the BRAM byte port into an external byte-wide memory.
// Optional build macro: WB_CHECKSUM_EN appends a mod-256 checksum byte
// after the drained frame and exposes it on csum.
module pack_writeback #(
  parameter int unsigned WORDS     = 512,
  parameter logic [17:0] BASE_ADDR = 18'h00000
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        EN_B,
  output logic        W_B,
  output logic [8:0]  ADDR_B,
  output logic [31:0] DIN_B,
  output logic        EN_A,
  output logic [10:0] ADDR_A,
  input  logic [7:0]  DOUT_A,
  output logic        mem_we,
  output logic [17:0] mem_address,
  output logic [7:0]  mem_data_in,
  output logic        complete,
  output logic [7:0]  csum
);

  localparam logic [8:0]  LAST_WORD = 9'(WORDS - 1);
  localparam logic [10:0] LAST_BYTE = 11'(4 * WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;

  // Pack side
  logic [1:0]  lane_r;
  logic [8:0]  word_idx_r;
  logic [23:0] word_r;        // lanes 0..2; lane 3 goes straight into DIN_B
  logic        pack_done_r;   // last word latched, its write is in flight
  logic        in_ready_r;
  logic        en_b_r;
  logic        w_b_r;
  logic [8:0]  addr_b_r;
  logic [31:0] din_b_r;
  logic        accept_s;

  // Drain side
  logic        en_a_r;
  logic [10:0] addr_a_r;
  logic        we_r;
  logic        wlast_r;       // current memory write carries the final data byte
  logic [17:0] waddr_r;
  logic        complete_r;
  logic        drain_done_s;

`ifdef WB_CHECKSUM_EN
  localparam logic [17:0] CSUM_ADDR = 18'(BASE_ADDR + 18'(4 * WORDS));

  logic        wcsum_r;       // current memory write carries the checksum
  logic [7:0]  csum_r;

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    sum8 = acc + b;
  endfunction
`endif

  // Byte handshake and end-of-drain detection
  always_comb begin
    accept_s     = 1'b0;
    drain_done_s = 1'b0;
    if ((state_r == PACK) && in_ready_r && in_valid) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
`ifdef WB_CHECKSUM_EN
    drain_done_s = we_r && wcsum_r;
`else
    drain_done_s = we_r && wlast_r;
`endif
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = PACK;
        end else begin
          state_s = IDLE;
        end
      end
      PACK: begin
        // Leave only after the final word's write cycle has been issued
        if (pack_done_r) begin
          state_s = DRAIN;
        end else begin
          state_s = PACK;
        end
      end
      DRAIN: begin
        if (drain_done_s) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        if (!start) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Pack datapath: lane assembly and one-cycle BRAM word write
  always_ff @(posedge CLK) begin
    if (!rst) begin
      lane_r      <= 2'd0;
      word_idx_r  <= 9'd0;
      word_r      <= 24'h000000;
      pack_done_r <= 1'b0;
      in_ready_r  <= 1'b0;
      en_b_r      <= 1'b0;
      w_b_r       <= 1'b0;
      addr_b_r    <= 9'd0;
      din_b_r     <= 32'h00000000;
    end else begin
      en_b_r <= 1'b0;
      w_b_r  <= 1'b0;
      if ((state_r == IDLE) && start) begin
        lane_r      <= 2'd0;
        word_idx_r  <= 9'd0;
        pack_done_r <= 1'b0;
        in_ready_r  <= 1'b1;
      end else if (accept_s) begin
        lane_r <= lane_r + 2'd1;
        case (lane_r)
          2'd0: word_r[7:0]   <= in_data;
          2'd1: word_r[15:8]  <= in_data;
          2'd2: word_r[23:16] <= in_data;
          2'd3: begin
            // Word complete: write it next cycle while bytes keep flowing
            din_b_r    <= {in_data, word_r};
            addr_b_r   <= word_idx_r;
            en_b_r     <= 1'b1;
            w_b_r      <= 1'b1;
            word_idx_r <= word_idx_r + 9'd1;
            if (word_idx_r == LAST_WORD) begin
              in_ready_r  <= 1'b0;
              pack_done_r <= 1'b1;
            end
          end
          default: lane_r <= 2'd0;
        endcase
      end
    end
  end

  // Drain datapath: sequential byte reads and the memory write one cycle later
  always_ff @(posedge CLK) begin
    if (!rst) begin
      en_a_r     <= 1'b0;
      addr_a_r   <= 11'd0;
      we_r       <= 1'b0;
      wlast_r    <= 1'b0;
      waddr_r    <= 18'h00000;
      complete_r <= 1'b0;
`ifdef WB_CHECKSUM_EN
      wcsum_r    <= 1'b0;
      csum_r     <= 8'h00;
`endif
    end else begin
      we_r       <= 1'b0;
      wlast_r    <= 1'b0;
      complete_r <= (state_s == DONE);
`ifdef WB_CHECKSUM_EN
      wcsum_r    <= 1'b0;
`endif
      // Read address generator
      if ((state_r == PACK) && pack_done_r) begin
        en_a_r   <= 1'b1;
        addr_a_r <= 11'd0;
      end else if (en_a_r) begin
        if (addr_a_r == LAST_BYTE) begin
          en_a_r <= 1'b0;
        end else begin
          addr_a_r <= addr_a_r + 11'd1;
        end
      end
      // Memory write follows each read by exactly one cycle; address wraps mod 2^18
      if (en_a_r) begin
        we_r    <= 1'b1;
        waddr_r <= BASE_ADDR + {7'd0, addr_a_r};
        wlast_r <= (addr_a_r == LAST_BYTE);
      end
`ifdef WB_CHECKSUM_EN
      else if (we_r && wlast_r) begin
        we_r    <= 1'b1;
        wcsum_r <= 1'b1;
        waddr_r <= CSUM_ADDR;
      end
      // Checksum over drained bytes, restarted with each new frame
      if ((state_r == IDLE) && start) begin
        csum_r <= 8'h00;
      end else if (we_r && !wcsum_r) begin
        csum_r <= sum8(csum_r, DOUT_A);
      end
`endif
    end
  end

  // Write data: BRAM read data arrives in the write cycle itself, so it is
  // steered straight through; gated by the registered strobe so it is 0 when idle
  always_comb begin
    mem_data_in = 8'h00;
    if (we_r) begin
`ifdef WB_CHECKSUM_EN
      if (wcsum_r) begin
        mem_data_in = csum_r;
      end else begin
        mem_data_in = DOUT_A;
      end
`else
      mem_data_in = DOUT_A;
`endif
    end else begin
      mem_data_in = 8'h00;
    end
  end

  assign in_ready    = in_ready_r;
  assign EN_B        = en_b_r;
  assign W_B         = w_b_r;
  assign ADDR_B      = addr_b_r;
  assign DIN_B       = din_b_r;
  assign EN_A        = en_a_r;
  assign ADDR_A      = addr_a_r;
  assign mem_we      = we_r;
  assign mem_address = waddr_r;
  assign complete    = complete_r;
`ifdef WB_CHECKSUM_EN
  assign csum        = csum_r;
`else
  assign csum        = 8'h00;
`endif

endmodule

// File: tb/tb_pack_writeback.sv
// Directed bench for pack_writeback: two instances (WORDS=2/BASE=0 and
// WORDS=1/BASE=0x3FFFE), behavioural BRAM for each, table-driven frames.
module tb_pack_writeback;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst;

  logic        start0, in_valid0, in_ready0, en_b0, w_b0, en_a0, mem_we0, complete0;
  logic [7:0]  in_data0, dout_a0, mem_data_in0, csum0;
  logic [8:0]  addr_b0;
  logic [31:0] din_b0;
  logic [10:0] addr_a0;
  logic [17:0] mem_address0;

  logic        start1, in_valid1, in_ready1, en_b1, w_b1, en_a1, mem_we1, complete1;
  logic [7:0]  in_data1, dout_a1, mem_data_in1, csum1;
  logic [8:0]  addr_b1;
  logic [31:0] din_b1;
  logic [10:0] addr_a1;
  logic [17:0] mem_address1;

  pack_writeback #(.WORDS(2), .BASE_ADDR(18'h00000)) u0 (
    .CLK(CLK), .rst(rst), .start(start0), .in_valid(in_valid0), .in_data(in_data0),
    .in_ready(in_ready0), .EN_B(en_b0), .W_B(w_b0), .ADDR_B(addr_b0), .DIN_B(din_b0),
    .EN_A(en_a0), .ADDR_A(addr_a0), .DOUT_A(dout_a0), .mem_we(mem_we0),
    .mem_address(mem_address0), .mem_data_in(mem_data_in0), .complete(complete0), .csum(csum0));

  pack_writeback #(.WORDS(1), .BASE_ADDR(18'h3FFFE)) u1 (
    .CLK(CLK), .rst(rst), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .EN_B(en_b1), .W_B(w_b1), .ADDR_B(addr_b1), .DIN_B(din_b1),
    .EN_A(en_a1), .ADDR_A(addr_a1), .DOUT_A(dout_a1), .mem_we(mem_we1),
    .mem_address(mem_address1), .mem_data_in(mem_data_in1), .complete(complete1), .csum(csum1));

  // Behavioural dual-port BRAMs: word write port, byte read port with 1-cycle latency
  logic [31:0] bram0 [0:511];
  logic [31:0] bram1 [0:511];

  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] k);
    return w[8*k +: 8];
  endfunction

  always @(posedge CLK) begin
    if (en_b0 && w_b0) bram0[addr_b0] <= din_b0;
    if (en_a0) dout_a0 <= pick(bram0[addr_a0[10:2]], addr_a0[1:0]);
    if (en_b1 && w_b1) bram1[addr_b1] <= din_b1;
    if (en_a1) dout_a1 <= pick(bram1[addr_a1[10:2]], addr_a1[1:0]);
  end

  typedef struct packed { logic [17:0] addr; logic [7:0] data; } mw_t;
  typedef struct packed { logic [8:0] addr; logic [31:0] data; logic we; } bw_t;
  typedef struct { logic [7:0] din; logic [17:0] exp_addr; logic [7:0] exp_data; } vec_t;

  mw_t cap0[$], cap1[$], exp_m[$];
  bw_t bcap0[$], bcap1[$], exp_b[$];
  int  wcyc0[$];
  int  cyc = 0;

  // Capture every external-memory and BRAM write away from the active edge
  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (mem_we0) begin
      cap0.push_back('{addr: mem_address0, data: mem_data_in0});
      wcyc0.push_back(cyc);
    end
    if (mem_we1) cap1.push_back('{addr: mem_address1, data: mem_data_in1});
    if (en_b0 || w_b0) bcap0.push_back('{addr: addr_b0, data: din_b0, we: en_b0 & w_b0});
    if (en_b1 || w_b1) bcap1.push_back('{addr: addr_b1, data: din_b1, we: en_b1 & w_b1});
  end

  int errors = 0;
  int checks = 0;
  logic        csum_on;
  logic [7:0]  exp_csum;
  logic [17:0] exp_caddr;
  logic [7:0]  cur_bytes[$];
  vec_t vec0[$], vec1[$], vec2[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      start0 = s; in_valid0 = v; in_data0 = d;
    end else begin
      start1 = s; in_valid1 = v; in_data1 = d;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? in_ready0 : in_ready1;
  endfunction

  function automatic logic cmpl(input int sel);
    return (sel == 0) ? complete0 : complete1;
  endfunction

  task automatic set_exp(input vec_t v[$], input logic [17:0] caddr, input logic [7:0] csv);
    exp_m.delete();
    cur_bytes.delete();
    foreach (v[i]) begin
      exp_m.push_back('{addr: v[i].exp_addr, data: v[i].exp_data});
      cur_bytes.push_back(v[i].din);
    end
    exp_caddr = caddr;
`ifdef WB_CHECKSUM_EN
    exp_m.push_back('{addr: caddr, data: csv});
`endif
    exp_csum = csum_on ? csv : 8'h00;
  endtask

  task automatic clear_caps();
    cap0.delete(); cap1.delete(); bcap0.delete(); bcap1.delete(); wcyc0.delete();
  endtask

  // Start a frame and push all bytes; returns at the negedge after the last accept
  task automatic run_frame(input int sel, input int gap, input logic hold, output int stalls);
    int budget;
    stalls = 0;
    @(negedge CLK);
    drive(sel, 1'b1, 1'b0, 8'h00);
    @(negedge CLK);
    for (int i = 0; i < cur_bytes.size(); i++) begin
      if (i > 0) begin
        repeat (gap) begin
          drive(sel, hold, 1'b0, 8'h00);
          @(negedge CLK);
        end
      end
      drive(sel, hold, 1'b1, cur_bytes[i]);
      budget = 0;
      while (!rdy(sel) && budget < 20) begin
        stalls++; budget++;
        @(negedge CLK);
      end
      @(negedge CLK);
    end
    drive(sel, hold, 1'b0, 8'h00);
  endtask

  task automatic wait_complete(input int sel, input string tag);
    int budget = 0;
    while (!cmpl(sel) && budget < 100) begin
      budget++;
      @(negedge CLK);
    end
    chk($sformatf("%s complete", tag), 64'(cmpl(sel)), 64'(1'b1));
  endtask

  task automatic cmp_frame(input string tag, input mw_t got[$], input bw_t bgot[$]);
    chk($sformatf("%s mem_count", tag), 64'(got.size()), 64'(exp_m.size()));
    for (int i = 0; i < exp_m.size(); i++)
      if (i < got.size()) chk($sformatf("%s mem[%0d]", tag, i), 64'(got[i]), 64'(exp_m[i]));
    chk($sformatf("%s bram_count", tag), 64'(bgot.size()), 64'(exp_b.size()));
    for (int i = 0; i < exp_b.size(); i++)
      if (i < bgot.size()) chk($sformatf("%s bram[%0d]", tag, i), 64'(bgot[i]), 64'(exp_b[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int stalls;
    int n;
`ifdef WB_CHECKSUM_EN
    csum_on = 1'b1;
`else
    csum_on = 1'b0;
`endif
    // Frame tables: input byte, expected memory address, expected memory data
    for (int i = 0; i < 8; i++) vec0.push_back('{8'(8'h11 + i), 18'(i), 8'(8'h11 + i)});
    for (int i = 0; i < 8; i++) vec2.push_back('{8'(8'hA0 + i), 18'(i), 8'(8'hA0 + i)});
    vec1.push_back('{8'hFF, 18'h3FFFE, 8'hFF});
    vec1.push_back('{8'h01, 18'h3FFFF, 8'h01});
    vec1.push_back('{8'h10, 18'h00000, 8'h10});
    vec1.push_back('{8'h20, 18'h00001, 8'h20});

    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge CLK);
    chk("reset strobes", 64'({in_ready0, en_a0, en_b0, w_b0, mem_we0, complete0}), 64'(6'b0));
    chk("reset ADDR_A", 64'(addr_a0), 64'(11'd0));
    chk("reset ADDR_B/DIN_B", 64'({addr_b0, din_b0}), 64'(41'd0));
    chk("reset mem bus", 64'({mem_address0, mem_data_in0, csum0}), 64'(34'd0));
    rst = 1'b1;
    @(negedge CLK);

    // Back-to-back frame, WORDS=2
    clear_caps();
    set_exp(vec0, 18'h00008, 8'hA4);
    exp_b.delete();
    exp_b.push_back('{9'd0, 32'h14131211, 1'b1});
    exp_b.push_back('{9'd1, 32'h18171615, 1'b1});
    run_frame(0, 0, 1'b0, stalls);
    chk("b2b stalls", 64'(stalls), 64'd0);
    chk("b2b ready low after last", 64'(in_ready0), 64'(1'b0));
    chk("b2b last word write", 64'({en_b0, w_b0, addr_b0}), 64'({1'b1, 1'b1, 9'd1}));
    wait_complete(0, "b2b");
    cmp_frame("b2b", cap0, bcap0);
    chk("b2b csum", 64'(csum0), 64'(exp_csum));
    if (wcyc0.size() > 0)
      chk("b2b mem_we contiguous", 64'(wcyc0[wcyc0.size()-1] - wcyc0[0]), 64'(exp_m.size() - 1));
    @(negedge CLK);
    chk("b2b complete drops", 64'(complete0), 64'(1'b0));

    // Same frame with in_valid low every other cycle
    clear_caps();
    run_frame(0, 1, 1'b0, stalls);
    chk("gap stalls", 64'(stalls), 64'd0);
    wait_complete(0, "gap");
    cmp_frame("gap", cap0, bcap0);
    @(negedge CLK);

    // WORDS=1 with address wrap and checksum data
    clear_caps();
    set_exp(vec1, 18'h00002, 8'h30);
    exp_b.delete();
    exp_b.push_back('{9'd0, 32'h201001FF, 1'b1});
    run_frame(1, 0, 1'b0, stalls);
    chk("wrap ready low after last", 64'(in_ready1), 64'(1'b0));
    wait_complete(1, "wrap");
    cmp_frame("wrap", cap1, bcap1);
    chk("wrap csum", 64'(csum1), 64'(exp_csum));
    @(negedge CLK);

    // Reset after third drained byte, then a full new frame
    clear_caps();
    set_exp(vec0, 18'h00008, 8'hA4);
    run_frame(0, 0, 1'b0, stalls);
    n = 0;
    for (int t = 0; t < 50 && n < 3; t++) begin
      @(negedge CLK);
      if (mem_we0) n++;
    end
    chk("abort third write seen", 64'(n), 64'd3);
    rst = 1'b0;
    @(negedge CLK);
    chk("abort outputs", 64'({mem_we0, complete0, en_a0, in_ready0, en_b0}), 64'(5'b0));
    rst = 1'b1;
    repeat (2) @(negedge CLK);
    chk("abort write count", 64'(cap0.size()), 64'd3);
    clear_caps();
    set_exp(vec2, 18'h00008, 8'h1C);
    exp_b.delete();
    exp_b.push_back('{9'd0, 32'hA3A2A1A0, 1'b1});
    exp_b.push_back('{9'd1, 32'hA7A6A5A4, 1'b1});
    run_frame(0, 0, 1'b0, stalls);
    wait_complete(0, "rerun");
    cmp_frame("rerun", cap0, bcap0);
    chk("rerun csum", 64'(csum0), 64'(exp_csum));
    @(negedge CLK);

    // start held high through DONE
    clear_caps();
    set_exp(vec0, 18'h00008, 8'hA4);
    exp_b.delete();
    exp_b.push_back('{9'd0, 32'h14131211, 1'b1});
    exp_b.push_back('{9'd1, 32'h18171615, 1'b1});
    run_frame(0, 0, 1'b1, stalls);
    wait_complete(0, "hold");
    for (int t = 0; t < 5; t++) begin
      @(negedge CLK);
      chk($sformatf("hold complete %0d", t), 64'({complete0, in_ready0}), 64'(2'b10));
    end
    cmp_frame("hold", cap0, bcap0);
    drive(0, 1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    chk("hold complete drops", 64'(complete0), 64'(1'b0));
    @(negedge CLK);
    chk("hold no new frame", 64'({in_ready0, en_a0}), 64'(2'b00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
